// File: rtl/sweep_pkg.sv
//------------------------------------------------------------------
// sweep_pkg - shared state encoding and default width for sweep_ctrl
// Revision: 1.0
//------------------------------------------------------------------
`default_nettype none

package sweep_pkg;

  localparam int unsigned DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/updown_cnt.sv
//------------------------------------------------------------------
// updown_cnt - loadable up/down counter holding the sweep value
// Revision: 1.0
//------------------------------------------------------------------
`default_nettype none

module updown_cnt
  import sweep_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  input  logic             up_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i) begin
      cnt_q <= up_i ? cnt_q + WIDTH'(1) : cnt_q - WIDTH'(1);
    end
  end

  assign q_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/sweep_ctrl.sv
//------------------------------------------------------------------
// sweep_ctrl - one-shot / ping-pong sweep between latched LO/HI limits
// Revision: 1.0
//------------------------------------------------------------------
`default_nettype none

module sweep_ctrl
  import sweep_pkg::*;
#(
  parameter int unsigned STEP_DIV = 1,
  parameter int unsigned WIDTH    = DEF_WIDTH
) (
  input  logic             C,
  input  logic             CLR,
  input  logic             START,
  input  logic             STOP,
  input  logic             MODE,
  input  logic [WIDTH-1:0] LO,
  input  logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] Q,
  output logic             DIR,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR
);

  localparam int unsigned PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  state_e           state_q, state_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic [WIDTH-1:0] lo_q, lo_d, hi_q, hi_d;
  logic             mode_q, mode_d;
  logic             dir_q, dir_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             cnt_load, cnt_en, cnt_up;
  logic             tick;

  assign tick = (pre_q == PW'(STEP_DIV - 1));

  always_ff @(posedge C) begin
    if (CLR) begin
      state_q <= IDLE;
      pre_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      mode_q  <= 1'b0;
      dir_q   <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pre_d    = pre_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    mode_d   = mode_q;
    dir_d    = dir_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    cnt_up   = 1'b1;
    case (state_q)
      IDLE: begin
        if (START) begin
          if (LO <= HI) begin
            lo_d     = LO;
            hi_d     = HI;
            mode_d   = MODE;
            dir_d    = 1'b1;
            pre_d    = '0;
            cnt_load = 1'b1;
            state_d  = UP;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      UP: begin
        if (STOP) begin
          state_d = IDLE;
        end else if (!tick) begin
          pre_d = pre_q + PW'(1);
        end else begin
          pre_d = '0;
          // Reaching a limit costs a whole tick: Q holds while direction/state change.
          if (Q < hi_q) begin
            cnt_en = 1'b1;
          end else if (mode_q) begin
            dir_d   = 1'b0;
            state_d = DOWN;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      DOWN: begin
        if (STOP) begin
          state_d = IDLE;
        end else if (!tick) begin
          pre_d = pre_q + PW'(1);
        end else begin
          pre_d = '0;
          if (Q > lo_q) begin
            cnt_en = 1'b1;
            cnt_up = 1'b0;
          end else begin
            dir_d   = 1'b1;
            state_d = UP;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  updown_cnt #(.WIDTH(WIDTH)) u_cnt (
    .clk_i      (C),
    .rst_i      (CLR),
    .load_i     (cnt_load),
    .load_val_i (LO),
    .en_i       (cnt_en),
    .up_i       (cnt_up),
    .q_o        (Q)
  );

  assign DIR  = dir_q;
  assign BUSY = (state_q != IDLE);
  assign DONE = done_q;
  assign ERR  = err_q;

endmodule

`default_nettype wire

// File: doc/sweep_ctrl.md
SWEEP_CTRL -- requirements
Module: sweep_ctrl

Interface
REQ-001 Parameter STEP_DIV, default 1: clock cycles per count step; legal range 1-16.
REQ-002 Parameter WIDTH, default 4: counter and limit width.
REQ-003 C  input  1: the single clock; all state changes on the rising edge.
REQ-004 CLR  input  1: reset, synchronous and active-high.
REQ-005 START  input  1: level, sampled each cycle; begins a sweep when the block is idle.
REQ-006 STOP  input  1: level; aborts an active sweep.
REQ-007 MODE  input  1: 0 = one-shot sweep LO->HI; 1 = ping-pong LO<->HI until STOP.
REQ-008 LO  input  WIDTH: lower limit, unsigned.
REQ-009 HI  input  WIDTH: upper limit, unsigned.
REQ-010 Q  output  WIDTH: current count value.
REQ-011 DIR  output  1: current direction; 1 = up, 0 = down.
REQ-012 BUSY  output  1: high while a sweep is active.
REQ-013 DONE  output  1: one-cycle pulse at one-shot completion.
REQ-014 ERR  output  1: one-cycle pulse when START is rejected.

Function
REQ-015 FSM states SHALL be IDLE, UP, DOWN; BUSY SHALL be 1 exactly in UP/DOWN.
REQ-016 IDLE, START=1, LO<=HI: latch LO/HI/MODE; next cycle Q=LO, DIR=1, state UP, prescaler=0.
REQ-017 IDLE, START=1, LO>HI: ERR=1 next cycle for one cycle; stay IDLE; Q and DIR unchanged.
REQ-018 Prescaler: tick asserts every STEP_DIV-th cycle in UP/DOWN; first tick STEP_DIV cycles after entry.
REQ-019 Limit inputs and MODE changes during UP/DOWN SHALL be ignored; latched values govern the sweep.
REQ-020 UP, tick, Q<HI: Q=Q+1.
REQ-021 UP, tick, Q==HI, MODE=0: Q holds; DONE=1 one cycle; next state IDLE.
REQ-022 UP, tick, Q==HI, MODE=1: Q holds; DIR=0; next state DOWN (turnaround consumes one tick).
REQ-023 DOWN, tick, Q>LO: Q=Q-1.
REQ-024 DOWN, tick, Q==LO: Q holds; DIR=1; next state UP.
REQ-025 LO==HI: one-shot completes on the first tick; ping-pong toggles DIR on every tick with Q constant.
REQ-026 STOP=1 in UP/DOWN: next state IDLE; Q and DIR freeze; no DONE. STOP has priority over tick and over START.
REQ-027 START while BUSY SHALL be ignored; STOP in IDLE SHALL be ignored.
REQ-028 Q SHALL never leave [LO,HI] during a sweep; no wrap-around is permitted.

Reset
REQ-029 CLR=1 SHALL force next edge: state IDLE, Q=0, DIR=1, BUSY=0, DONE=0, ERR=0, prescaler=0, latched limits=0.
REQ-030 CLR SHALL take priority over every other input, including mid-sweep.

Structure
REQ-031 Shared package sweep_pkg SHALL hold the state encoding (IDLE/UP/DOWN) and the default WIDTH constant.
REQ-032 A sub-module updown_cnt SHALL hold Q, with load, enable and direction inputs; sweep_ctrl holds the FSM and prescaler.

Verification (STEP_DIV=1 unless noted)
REQ-033 CLR high for 2 cycles -> Q=0, DIR=1, BUSY=0, DONE=0, ERR=0.
REQ-034 One-shot: START pulse, LO=3, HI=6, MODE=0 -> Q=3,4,5,6 on consecutive cycles; next cycle DONE=1, BUSY=0; Q stays 6.
REQ-035 Ping-pong: LO=2, HI=4, MODE=1 -> Q=2,3,4,4,3,2,2,3; DIR=0 from the second 4; DIR=1 from the second 2.
REQ-036 Reject: LO=9, HI=5, START -> ERR=1 for one cycle; BUSY=0; Q unchanged.
REQ-037 Abort: during ping-pong at Q=3, assert STOP and START together -> IDLE next cycle; Q=3 frozen; no DONE; START ignored.
REQ-038 STEP_DIV=3, LO=0, HI=15, MODE=0: Q steps every 3 cycles; CLR at Q=7 -> Q=0, BUSY=0 next edge; new START restarts cleanly from LO.
